// File: rtl/pipe_hazard_ctrl.sv
// Hazard control beside IF/ID and ID/EX: forwarding selects, load-use stall and redirect flush.
// Outputs are combinational (zero latency); stall holds IF/ID and bubbles ID/EX, flush clears both.
module pipe_hazard_ctrl #(
    parameter int N_STAGES     = 3,
    parameter int ADDR_W       = 5,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int SEL_W        = $clog2(N_STAGES + 1),
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs_i,
    input  logic [ADDR_W-1:0] id_rt_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic [ADDR_W-1:0] id_dest_i,
    input  logic              redirect_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic [SEL_W-1:0]  fwd_rs_o,
    output logic [SEL_W-1:0]  fwd_rt_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    logic              r_v    [1:N_STAGES];
    logic              r_rw   [1:N_STAGES];
    logic              r_mr   [1:N_STAGES];
    logic [ADDR_W-1:0] r_dest [1:N_STAGES];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FC_W-1:0]   r_cnt;
    logic [FC_W-1:0]   w_cnt_nxt;

    logic [SEL_W-1:0]  w_rs_sel;
    logic [SEL_W-1:0]  w_rt_sel;
    logic              w_rs_mr;
    logic              w_rt_mr;
    logic              w_rs_lu;
    logic              w_rt_lu;
    logic              w_issue;

    // Scan oldest to youngest so the youngest matching producer overwrites the result.
    always_comb begin
        w_rs_sel = '0;
        w_rs_mr  = 1'b0;
        w_rt_sel = '0;
        w_rt_mr  = 1'b0;
        for (int k = N_STAGES; k >= 1; k--) begin
            if (r_v[k] && r_rw[k] && (r_dest[k] == id_rs_i) && (id_rs_i != '0)) begin
                w_rs_sel = SEL_W'(k);
                w_rs_mr  = r_mr[k];
            end
            if (r_v[k] && r_rw[k] && (r_dest[k] == id_rt_i) && (id_rt_i != '0)) begin
                w_rt_sel = SEL_W'(k);
                w_rt_mr  = r_mr[k];
            end
        end
    end

    assign w_rs_lu  = id_uses_rs_i && w_rs_mr && (w_rs_sel <= SEL_W'(LOAD_LAT));
    assign w_rt_lu  = id_uses_rt_i && w_rt_mr && (w_rt_sel <= SEL_W'(LOAD_LAT));

    assign fwd_rs_o = id_uses_rs_i ? w_rs_sel : '0;
    assign fwd_rt_o = id_uses_rt_i ? w_rt_sel : '0;
    assign flush_o  = redirect_i || (r_state == S_FLUSH);
    assign stall_o  = id_valid_i && !flush_o && (w_rs_lu || w_rt_lu);
    assign w_issue  = !stall_o && !flush_o;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 1; k <= N_STAGES; k++) begin
                r_v[k]    <= 1'b0;
                r_rw[k]   <= 1'b0;
                r_mr[k]   <= 1'b0;
                r_dest[k] <= '0;
            end
        end else begin
            r_v[1]    <= w_issue && id_valid_i;
            r_rw[1]   <= w_issue && id_reg_write_i;
            r_mr[1]   <= w_issue && id_mem_read_i;
            r_dest[1] <= w_issue ? id_dest_i : '0;
            for (int k = 2; k <= N_STAGES; k++) begin
                r_v[k]    <= r_v[k-1];
                r_rw[k]   <= r_rw[k-1];
                r_mr[k]   <= r_mr[k-1];
                r_dest[k] <= r_dest[k-1];
            end
        end
    end

    // A redirect always reloads, so a pulse during a window restarts it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (redirect_i) begin
            w_cnt_nxt   = FC_W'(FLUSH_CYCLES - 1);
            w_state_nxt = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
        end else if (r_state == S_FLUSH) begin
            w_cnt_nxt = r_cnt - FC_W'(1);
            if (r_cnt == FC_W'(1)) begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (redirect_i && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed literal checks plus randomized run against a queue-based model.
module tb_pipe_hazard_ctrl;

    localparam int N_STAGES     = 3;
    localparam int LOAD_LAT     = 1;
    localparam int FLUSH_CYCLES = 2;

    logic       clk;
    logic       reset;
    logic       id_valid_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic       id_uses_rs_i;
    logic       id_uses_rt_i;
    logic       id_reg_write_i;
    logic       id_mem_read_i;
    logic [4:0] id_dest_i;
    logic       redirect_i;

    logic        stall_o,  flush_o;
    logic [1:0]  fwd_rs_o, fwd_rt_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    logic        s_stall_o, s_flush_o;
    logic [1:0]  s_fwd_rs_o, s_fwd_rt_o;
    logic [3:0]  s_stall_cnt_o, s_flush_cnt_o;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i), .id_reg_write_i(id_reg_write_i),
        .id_mem_read_i(id_mem_read_i), .id_dest_i(id_dest_i), .redirect_i(redirect_i),
        .stall_o(stall_o), .flush_o(flush_o), .fwd_rs_o(fwd_rs_o), .fwd_rt_o(fwd_rt_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i), .id_reg_write_i(id_reg_write_i),
        .id_mem_read_i(id_mem_read_i), .id_dest_i(id_dest_i), .redirect_i(redirect_i),
        .stall_o(s_stall_o), .flush_o(s_flush_o), .fwd_rs_o(s_fwd_rs_o), .fwd_rt_o(s_fwd_rt_o),
        .stall_cnt_o(s_stall_cnt_o), .flush_cnt_o(s_flush_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: hist[0] is the instruction one stage past ID, hist[i] is i+1 stages past.
    typedef struct packed {
        bit       v;
        bit       rw;
        bit       mr;
        bit [4:0] dest;
    } ent_t;

    ent_t hist[$];
    int   sc = 0, fc = 0, cyc = 0, last_redir = -1000;
    bit   model_ok = 0;
    bit   stall_e, flush_e;

    function automatic void lookup(input int src, output int sel, output bit mr);
        sel = 0;
        mr  = 0;
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i].v && hist[i].rw && int'(hist[i].dest) == src && src != 0) begin
                sel = i + 1;
                mr  = hist[i].mr;
                break;
            end
        end
    endfunction

    always @(negedge clk) begin
        int  rs_k, rt_k;
        bit  rs_m, rt_m;
        if (model_ok) begin
            flush_e = redirect_i || (cyc - last_redir < FLUSH_CYCLES);
            lookup(int'(id_rs_i), rs_k, rs_m);
            lookup(int'(id_rt_i), rt_k, rt_m);
            if (!id_uses_rs_i) begin rs_k = 0; rs_m = 0; end
            if (!id_uses_rt_i) begin rt_k = 0; rt_m = 0; end
            stall_e = id_valid_i && !flush_e &&
                      ((rs_m && rs_k <= LOAD_LAT) || (rt_m && rt_k <= LOAD_LAT));
            chk("stall",     stall_o,       stall_e);
            chk("flush",     flush_o,       flush_e);
            chk("fwd_rs",    fwd_rs_o,      rs_k);
            chk("fwd_rt",    fwd_rt_o,      rt_k);
            chk("stall_cnt", stall_cnt_o,   sc);
            chk("flush_cnt", flush_cnt_o,   fc);
            chk("sat_stall", s_stall_cnt_o, (sc > 15) ? 15 : sc);
            chk("sat_flush", s_flush_cnt_o, (fc > 15) ? 15 : fc);
        end
    end

    always @(posedge clk) begin
        ent_t e;
        if (!reset) begin
            hist.delete();
            sc = 0;
            fc = 0;
            last_redir = -1000;
            model_ok = 1;
        end else if (model_ok) begin
            e = '0;
            if (!stall_e && !flush_e) e = '{id_valid_i, id_reg_write_i, id_mem_read_i, id_dest_i};
            hist.push_front(e);
            if (hist.size() > N_STAGES) void'(hist.pop_back());
            if (stall_e) sc++;
            if (redirect_i) begin
                fc++;
                last_redir = cyc;
            end
        end
        cyc++;
    end

    task automatic drv(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit rw, input bit mr, input int dest, input bit redir);
        id_valid_i     = v;
        id_rs_i        = 5'(rs);
        id_rt_i        = 5'(rt);
        id_uses_rs_i   = urs;
        id_uses_rt_i   = urt;
        id_reg_write_i = rw;
        id_mem_read_i  = mr;
        id_dest_i      = 5'(dest);
        redirect_i     = redir;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic nop;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rnd(input bit allow_redir);
        drv($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
            allow_redir && ($urandom_range(0, 15) == 0));
    endtask

    initial begin
        reset = 1'b0;
        rnd(0);
        nxt;
        rnd(0);
        @(negedge clk);
        chk("rst_stall", stall_o, 0);
        chk("rst_fwd_rs", fwd_rs_o, 0);
        chk("rst_fwd_rt", fwd_rt_o, 0);
        chk("rst_scnt", stall_cnt_o, 0);
        chk("rst_fcnt", flush_cnt_o, 0);
        nxt;
        reset = 1'b1;
        nop;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_flush_after", flush_o, 0);
            nxt;
        end

        // ALU back-to-back dependence
        drv(1, 0, 0, 0, 0, 1, 0, 8, 0); nxt;
        drv(1, 8, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk); chk("alu_fwd1", fwd_rs_o, 1); chk("alu_nostall", stall_o, 0); nxt;
        @(negedge clk); chk("alu_fwd2", fwd_rs_o, 2); nxt;

        // Load-use
        drv(1, 0, 0, 0, 0, 1, 1, 9, 0); nxt;
        drv(1, 0, 9, 0, 1, 0, 0, 0, 0);
        @(negedge clk); chk("lu_stall", stall_o, 1); nxt;
        @(negedge clk); chk("lu_release", stall_o, 0); chk("lu_fwd_rt", fwd_rt_o, 2);
        chk("lu_scnt", stall_cnt_o, 1); nxt;

        // Register zero and shadowing
        drv(1, 0, 0, 0, 0, 1, 0, 0, 0); nxt;
        drv(1, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk); chk("r0_rs", fwd_rs_o, 0); chk("r0_rt", fwd_rt_o, 0); nxt;
        drv(1, 0, 0, 0, 0, 1, 1, 5, 0); nxt;
        drv(1, 0, 0, 0, 0, 1, 0, 5, 0); nxt;
        drv(1, 5, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk); chk("shadow_fwd", fwd_rs_o, 1); chk("shadow_nostall", stall_o, 0); nxt;

        // Flush windows
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); chk("fl_t", flush_o, 1); nxt;
        nop;
        @(negedge clk); chk("fl_t1", flush_o, 1); nxt;
        @(negedge clk); chk("fl_t2", flush_o, 0); chk("fl_cnt", flush_cnt_o, 1); nxt;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1); nxt;
        @(negedge clk); chk("fl2_t1", flush_o, 1); nxt;
        nop;
        @(negedge clk); chk("fl2_t2", flush_o, 1); nxt;
        @(negedge clk); chk("fl2_t3", flush_o, 0); chk("fl2_cnt", flush_cnt_o, 3); nxt;

        // Stall condition coinciding with a redirect
        drv(1, 0, 0, 0, 0, 1, 1, 9, 0); nxt;
        drv(1, 0, 9, 0, 1, 0, 0, 0, 1);
        @(negedge clk); chk("sr_stall", stall_o, 0); chk("sr_flush", flush_o, 1); nxt;
        drv(1, 0, 9, 0, 1, 0, 0, 0, 0);
        @(negedge clk); chk("sr_fwd_rt", fwd_rt_o, 2); chk("sr_scnt", stall_cnt_o, 1); nxt;
        nop; nxt; nop; nxt;

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drv(1, 0, 0, 0, 0, 1, 1, 9, 0); nxt;
            drv(1, 0, 9, 0, 1, 0, 0, 0, 0); nxt;
        end
        nop;
        @(negedge clk); chk("sat_15", s_stall_cnt_o, 15); chk("wide_21", stall_cnt_o, 21); nxt;

        // Randomized run with occasional mid-operation resets
        for (int i = 0; i < 3000; i++) begin
            rnd(1);
            reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            nxt;
        end
        reset = 1'b1;

        // Reset while a load and a flush window are in flight
        drv(1, 0, 0, 0, 0, 1, 1, 9, 0); nxt;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1); nxt;
        reset = 1'b0;
        nop; nxt;
        reset = 1'b1;
        drv(1, 0, 9, 0, 1, 0, 0, 0, 0);
        @(negedge clk); chk("mr_stall", stall_o, 0); chk("mr_flush", flush_o, 0);
        chk("mr_fwd", fwd_rt_o, 0); chk("mr_fcnt", flush_cnt_o, 0); nxt;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard controller for the pipelined MIPS core. It keeps its own shift-register record of every instruction issued past ID: valid, reg_write, mem_read and destination register, tracked over N_STAGES downstream stages. From that record it produces:
- operand-forwarding selects for the instruction in ID;
- a load-use stall;
- a multi-cycle flush after a taken branch or jump;
- saturating stall and flush event counters.

It sits beside the IF/ID and ID/EX pipeline registers and drives their enable and clear controls.

## Interface
- N_STAGES, 3, number of post-ID stages tracked (entry 1 = EX … entry N_STAGES = WB); ≥2
- ADDR_W, 5, register address width
- LOAD_LAT, 1, number of stages after EX before load data can be forwarded; 1 ≤ LOAD_LAT < N_STAGES
- FLUSH_CYCLES, 2, number of cycles flush_o is held per redirect; ≥1
- SEL_W, $clog2(N_STAGES+1), width of the forward selects (derived)
- CNT_W, 32, width of the statistics counters

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- id_valid_i  in  1  ID holds a valid instruction
- id_rs_i  in  ADDR_W  rs field of the ID instruction
- id_rt_i  in  ADDR_W  rt field of the ID instruction
- id_uses_rs_i  in  1  ID instruction reads rs
- id_uses_rt_i  in  1  ID instruction reads rt
- id_reg_write_i  in  1  ID instruction writes a register
- id_mem_read_i  in  1  ID instruction is a load
- id_dest_i  in  ADDR_W  final destination register (after the rd/rt/31 muxing)
- redirect_i  in  1  taken branch or jump resolved this cycle (one-cycle pulse)
- stall_o  out  1  hold the PC and IF/ID; insert a bubble into ID/EX
- flush_o  out  1  clear IF/ID and ID/EX
- fwd_rs_o  out  SEL_W  0 = register file; k = result held by entry k
- fwd_rt_o  out  SEL_W  same encoding, for rt
- stall_cnt_o  out  CNT_W  number of stall cycles, saturating
- flush_cnt_o  out  CNT_W  number of redirect events, saturating

## Operation
- **Tracking table.** Entries 1..N_STAGES, each holding {v, rw, mr, dest}.
  - Every cycle, entry k+1 takes the old value of entry k.
  - Entry 1 takes {id_valid_i, id_reg_write_i, id_mem_read_i, id_dest_i} when stall_o=0 and flush_o=0. Otherwise entry 1 takes a bubble (all fields 0).
  - The old value of entry N_STAGES is discarded; that instruction has retired to the register file.
- **Match rule.** Entry k matches source register s when v=1, rw=1, dest==s and s≠0. Writes to register 0 never match.
- **Forwarding.**
  - fwd_rs_o is the smallest k whose entry matches id_rs_i, when id_uses_rs_i=1; otherwise 0.
  - fwd_rt_o follows the same rule for rt.
  - Only the nearest (youngest) producer is selected.
- **Load-use stall.** stall_o=1 when id_valid_i=1, flush_o=0, and for either used source the nearest matching entry k has mr=1 and k ≤ LOAD_LAT.
  - A younger non-load producer for the same register masks an older load. No stall in that case.
- **Flush state machine.**
  - States: IDLE (cnt=0) and FLUSH (cnt≠0).
  - flush_o = redirect_i | (cnt≠0).
  - On redirect_i, cnt loads FLUSH_CYCLES−1, so flush_o is high for FLUSH_CYCLES consecutive cycles, starting in the redirect cycle.
  - While in FLUSH, cnt decrements and the state returns to IDLE at 0.
  - A redirect_i during FLUSH reloads cnt; the window restarts.
  - flush_o has priority: stall_o is forced to 0 whenever flush_o=1.
- **Counters.**
  - stall_cnt_o increments in each cycle with stall_o=1.
  - flush_cnt_o increments in each cycle with redirect_i=1.
  - Both saturate at all-ones and never wrap.

## Timing
- **Reset.** reset=0 sampled at a rising edge clears all entries, cnt, stall_cnt_o and flush_cnt_o.
  - After reset: stall_o=0, fwd_rs_o=0, fwd_rt_o=0, counters 0.
  - flush_o equals redirect_i, which is 0 under normal reset conditions.
- **Reset mid-operation.** In-flight entries and any flush window in progress are discarded. No residual stall or flush follows the reset.
- **Output paths.** stall_o, flush_o, fwd_rs_o and fwd_rt_o are combinational from the current table, cnt and the ID/redirect inputs, with zero-cycle latency. The table, cnt and counters update only on the rising edge.
- **Stall duration.** A load-use stall lasts exactly LOAD_LAT+1−k cycles, where k is the load's entry position when the dependent instruction reaches ID. With the defaults, a load immediately followed by its consumer gives a 1-cycle stall, and the consumer then sees fwd=2.
- **Simultaneous events.**
  - Stall condition together with redirect_i: the flush wins, a bubble is inserted, and the stall counter does not increment.
  - id_valid_i=0: no stall is raised; forward selects are still computed.

## Test plan
- Reset: drive reset low for 2 cycles with random inputs. Required: stall_o=0, fwd_rs_o=0, fwd_rt_o=0, both counters 0, and for 3 cycles after release flush_o=0 with redirect_i=0.
- Back-to-back ALU dependence: issue add $8 (dest 8), then an instruction reading rs=8. Required: fwd_rs_o=1, stall_o=0. The following cycle, a second reader of rs=8 sees fwd_rs_o=2.
- Load-use: issue lw $9 (mr=1, dest 9), then a reader with rt=9. Required: stall_o=1 for 1 cycle, entry 1 holds a bubble, then fwd_rt_o=2, and stall_cnt_o=1.
- Register 0 and shadowing:
  - Write to $0, then read $0. Required: fwd=0.
  - lw $5 followed by add $5, then a read of $5. Required: fwd=1, stall_o=0.
- Flush: pulse redirect_i at cycle t. Required: flush_o=1 at t and t+1, 0 at t+2; flush_cnt_o=1. A second pulse at t+1 keeps flush_o high through t+2.
- Saturation: with CNT_W=4, hold the stall condition for 20 cycles. Required: stall_cnt_o stops at 15.
